// File: rtl/simplez_mem_arbiter_pkg.sv
// Shared types and defaults for the Simplez RAM arbiter: FSM state encoding,
// requester IDs and default RAM geometry.
package simplez_pkg;

  localparam int AW_DEF = 9;
  localparam int DW_DEF = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_CPU = 2'd1,
    GNT_LDR = 2'd2
  } state_e;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_LDR = 1'b1
  } req_id_e;

endpackage

// File: rtl/simplez_mem_arbiter_pick2.sv
// Combinational winner select between CPU and loader requests.
// SIMPLEZ_MEM_ARB_LDR_PRIO_EN selects fixed loader priority instead of round-robin.
module simplez_arb_pick2
  import simplez_pkg::*;
(
  input  logic cpu_req_i,
  input  logic ldr_req_i,
  input  logic last_i,
  output logic valid_o,
  output logic winner_o
);

`ifdef SIMPLEZ_MEM_ARB_LDR_PRIO_EN
  logic unused_last;
  assign unused_last = last_i;

  // Loader always wins when it asks.
  always_comb begin
    valid_o  = cpu_req_i | ldr_req_i;
    winner_o = REQ_CPU;
    if (ldr_req_i) begin
      winner_o = REQ_LDR;
    end else begin
      winner_o = REQ_CPU;
    end
  end
`else
  // On a tie the requester that was not served last wins.
  always_comb begin
    valid_o  = cpu_req_i | ldr_req_i;
    winner_o = REQ_CPU;
    if (cpu_req_i && ldr_req_i) begin
      winner_o = (last_i == REQ_CPU) ? REQ_LDR : REQ_CPU;
    end else if (ldr_req_i) begin
      winner_o = REQ_LDR;
    end else begin
      winner_o = REQ_CPU;
    end
  end
`endif

endmodule

// File: rtl/simplez_mem_arbiter.sv
// Arbiter sharing the single-port Simplez RAM between CPU and serial loader.
// Every access takes a grant cycle followed by an idle cycle, so read returns never overlap.
module simplez_mem_arbiter
  import simplez_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic          ldr_gnt,
  output logic          ldr_rvalid,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  state_e  state_q, state_d;
  req_id_e last_q, last_d;
  logic    cpu_rvalid_q, ldr_rvalid_q;
  logic    pick_valid, pick_winner;

  simplez_arb_pick2 u_pick (
    .cpu_req_i (cpu_req),
    .ldr_req_i (ldr_req),
    .last_i    (last_q),
    .valid_o   (pick_valid),
    .winner_o  (pick_winner)
  );

  // State, last-served and read-return registers; reset drops any in-flight read.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      last_q       <= REQ_LDR;
      cpu_rvalid_q <= 1'b0;
      ldr_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      cpu_rvalid_q <= (state_q == GNT_CPU) && !cpu_we;
      ldr_rvalid_q <= (state_q == GNT_LDR) && !ldr_we;
    end
  end

  // Next state and RAM-side muxing; a grant state always returns to IDLE.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cpu_gnt   = 1'b0;
    ldr_gnt   = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = (pick_winner == REQ_LDR) ? GNT_LDR : GNT_CPU;
        end else begin
          state_d = IDLE;
        end
      end
      GNT_CPU: begin
        cpu_gnt   = 1'b1;
        mem_addr  = cpu_addr;
        mem_we    = cpu_we;
        mem_wdata = cpu_wdata;
        last_d    = REQ_CPU;
        state_d   = IDLE;
      end
      GNT_LDR: begin
        ldr_gnt   = 1'b1;
        mem_addr  = ldr_addr;
        mem_we    = ldr_we;
        mem_wdata = ldr_wdata;
        last_d    = REQ_LDR;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cpu_rvalid = cpu_rvalid_q;
  assign ldr_rvalid = ldr_rvalid_q;
  assign rdata      = mem_rdata;

endmodule
